// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of an array of 1-bit RAM cells: IDLE/ACCESS/RESP
// handshake with round-robin tie-break. Optional ERR output under RAM_ARB_ADDR_CHECK_EN.
module ram_arbiter #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic              DIN0,
  input  logic              DIN1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              DOUT,
  output logic              VALID0,
  output logic              VALID1,
  output logic [DEPTH-1:0]  RAM_SEL,
  output logic              RAM_READ,
  output logic              RAM_IN,
  input  logic [DEPTH-1:0]  RAM_OUT
`ifdef RAM_ARB_ADDR_CHECK_EN
  ,
  output logic              ERR
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              r_state, w_next;
  logic                r_owner;   // 1 = requester 1 holds the current transaction
  logic                r_last;    // requester served most recently
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_din;
  logic                r_dout;
  logic [DEPTH-1:0]    w_dec;
  logic                w_cell;
  logic                w_pick1;
  logic                w_start;

  // Out-of-range addresses decode to all zeros, so no cell is touched and reads return 0.
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < DEPTH; i++)
      w_dec[i] = (r_addr == ADDR_W'(i));
  end

  assign w_cell  = |(w_dec & RAM_OUT);
  assign w_pick1 = REQ1 & (~REQ0 | ~r_last);
  assign w_start = (r_state == IDLE) & (REQ0 | REQ1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    GNT0     = 1'b0;
    GNT1     = 1'b0;
    VALID0   = 1'b0;
    VALID1   = 1'b0;
    RAM_SEL  = '0;
    RAM_READ = 1'b0;
    RAM_IN   = 1'b0;
    case (r_state)
      IDLE: if (w_start) w_next = ACCESS;
      ACCESS: begin
        w_next   = RESP;
        GNT0     = ~r_owner;
        GNT1     = r_owner;
        RAM_SEL  = w_dec;
        RAM_READ = ~r_we;
        RAM_IN   = r_din;
      end
      RESP: begin
        w_next = IDLE;
        GNT0   = ~r_owner;
        GNT1   = r_owner;
        VALID0 = ~r_owner;
        VALID1 = r_owner;
      end
      default: w_next = IDLE;
    endcase
  end

  // Winner's request is frozen here for the whole transaction.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_din   <= 1'b0;
    end else if (w_start) begin
      r_owner <= w_pick1;
      r_last  <= w_pick1;
      r_we    <= w_pick1 ? WE1   : WE0;
      r_addr  <= w_pick1 ? ADDR1 : ADDR0;
      r_din   <= w_pick1 ? DIN1  : DIN0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                r_dout <= 1'b0;
    else if (r_state == ACCESS && !r_we)    r_dout <= w_cell;
  end

  assign DOUT = r_dout;

`ifdef RAM_ARB_ADDR_CHECK_EN
  assign ERR = (r_state == RESP) & ~(|w_dec);
`endif

endmodule
